// File: rtl/register_file.sv
// Multi-entry register file: one write port, two combinational read ports with
// write-first bypass, optional hardwired zero entry and a one-entry-per-cycle clear engine.
module register_file #(
  parameter int P_WIDTH    = 16,
  parameter int P_DEPTH    = 16,
  parameter int P_ZERO_REG = 0
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_WR_EN,
  input  logic [$clog2(P_DEPTH)-1:0] I_WR_ADDR,
  input  logic [P_WIDTH-1:0]         I_WR_DATA,
  input  logic [$clog2(P_DEPTH)-1:0] I_RD_ADDR_A,
  input  logic [$clog2(P_DEPTH)-1:0] I_RD_ADDR_B,
  output logic [P_WIDTH-1:0]         O_RD_DATA_A,
  output logic [P_WIDTH-1:0]         O_RD_DATA_B,
  input  logic                       I_CLEAR,
  output logic                       O_BUSY,
  output logic                       O_DONE
);

  localparam int L_AW = $clog2(P_DEPTH);
  localparam logic [L_AW-1:0] L_LAST = L_AW'(P_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic [L_AW-1:0]    ptr;
  logic               done;
  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic               wr_ok;

  // Writes only land in IDLE; entry 0 is read-only when hardwired to zero.
  assign wr_ok = I_WR_EN && (state == IDLE) &&
                 !((P_ZERO_REG != 0) && (I_WR_ADDR == '0));

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      for (int unsigned i = 0; i < P_DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok) mem[I_WR_ADDR] <= I_WR_DATA;
          if (I_CLEAR) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          if (ptr == L_LAST) begin
            state <= IDLE;
            ptr   <= '0;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    O_RD_DATA_A = mem[I_RD_ADDR_A];
    if (wr_ok && (I_WR_ADDR == I_RD_ADDR_A)) O_RD_DATA_A = I_WR_DATA;
    if ((P_ZERO_REG != 0) && (I_RD_ADDR_A == '0)) O_RD_DATA_A = '0;
  end

  always_comb begin
    O_RD_DATA_B = mem[I_RD_ADDR_B];
    if (wr_ok && (I_WR_ADDR == I_RD_ADDR_B)) O_RD_DATA_B = I_WR_DATA;
    if ((P_ZERO_REG != 0) && (I_RD_ADDR_B == '0)) O_RD_DATA_B = '0;
  end

  assign O_BUSY = (state == CLEAR);
  assign O_DONE = done;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one ordinary instance and one with a hardwired
// zero entry, sharing clock, reset and inputs.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic        clear;
  logic [15:0] rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
  logic        busy, done, z_busy, z_done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned busy_n, done_n;

  always #5 clk = ~clk;

  register_file #(.P_WIDTH(16), .P_DEPTH(16), .P_ZERO_REG(0)) dut (
    .I_CLK(clk), .I_NRESET(rst_n), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_RD_ADDR_A(rd_addr_a), .I_RD_ADDR_B(rd_addr_b),
    .O_RD_DATA_A(rd_data_a), .O_RD_DATA_B(rd_data_b), .I_CLEAR(clear),
    .O_BUSY(busy), .O_DONE(done)
  );

  register_file #(.P_WIDTH(16), .P_DEPTH(16), .P_ZERO_REG(1)) dut_z (
    .I_CLK(clk), .I_NRESET(rst_n), .I_WR_EN(wr_en), .I_WR_ADDR(wr_addr),
    .I_WR_DATA(wr_data), .I_RD_ADDR_A(rd_addr_a), .I_RD_ADDR_B(rd_addr_b),
    .O_RD_DATA_A(z_rd_data_a), .O_RD_DATA_B(z_rd_data_b), .I_CLEAR(clear),
    .O_BUSY(z_busy), .O_DONE(z_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      chk({tag, "_a"}, rd_data_a, exp);
      chk({tag, "_b"}, rd_data_b, exp);
    end
  endtask

  task automatic start_sweep();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clear = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    check_all("rst_rd", 16'h0000);

    // Write-first bypass on A, stored value on B after the edge
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
    #1;
    chk("byp_a", rd_data_a, 16'hBEEF);
    chk("byp_b_other", rd_data_b, 16'h0000);
    @(posedge clk);
    #1 wr_en = 1'b0; rd_addr_b = 4'd5;
    #1 chk("post_b5", rd_data_b, 16'hBEEF);

    // Hardwired zero entry vs ordinary entry 0
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    #1;
    chk("z_byp_a", z_rd_data_a, 16'h0000);
    chk("z_byp_b", z_rd_data_b, 16'h0000);
    chk("nz_byp_a", rd_data_a, 16'h1234);
    @(posedge clk);
    #1 wr_en = 1'b0;
    #1;
    chk("z_post_a", z_rd_data_a, 16'h0000);
    chk("z_post_b", z_rd_data_b, 16'h0000);
    chk("nz_post_b", rd_data_b, 16'h1234);

    // Full sweep over a loaded file
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h1000 + 16'(i));
    start_sweep();
    busy_n = 0; done_n = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
      if (j == 8) begin
        rd_addr_a = 4'd7; rd_addr_b = 4'd8;
        #1;
        chk("mid_r7", rd_data_a, 16'h0000);
        chk("mid_r8", rd_data_b, 16'h1008);
      end
      if (j == 16) chk("done_at_16", done, 1);
    end
    chk("sweep_busy_len", busy_n, 16);
    chk("sweep_done_cnt", done_n, 1);
    check_all("swept", 16'h0000);

    // Writes and clear requests during CLEAR are dropped
    start_sweep();
    busy_n = 0; done_n = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
      if (j == 1) begin
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hAAAA; clear = 1'b1; rd_addr_a = 4'd15;
        #1 chk("clr_nobyp_a", rd_data_a, 16'h0000);
      end
      if (j == 3) begin wr_en = 1'b0; clear = 1'b0; end
      if (j == 10) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hAAAA; rd_addr_b = 4'd3;
        #1 chk("clr_nobyp_b", rd_data_b, 16'h0000);
      end
      if (j == 11) wr_en = 1'b0;
    end
    chk("noq_busy_len", busy_n, 16);
    chk("noq_done_cnt", done_n, 1);
    @(negedge clk);
    rd_addr_a = 4'd15; rd_addr_b = 4'd3;
    #1;
    chk("noq_r15", rd_data_a, 16'h0000);
    chk("noq_r3", rd_data_b, 16'h0000);

    // Reset in the middle of a sweep
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h2000 + 16'(i));
    start_sweep();
    for (int j = 0; j < 3; j++) @(negedge clk);
    @(negedge clk);
    rd_addr_a = 4'd10; rd_addr_b = 4'd15;
    #1 chk("pre_rst_r10", rd_data_a, 16'h200A);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_r10", rd_data_a, 16'h0000);
    chk("mrst_r15", rd_data_b, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    done_n = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("mrst_no_done", done_n, 0);
    chk("mrst_busy_after", busy, 0);
    check_all("mrst_rd", 16'h0000);
    write_reg(4'd9, 16'h5A5A);
    rd_addr_b = 4'd9;
    #1 chk("post_rst_wr", rd_data_b, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
